alu_issue_unit: RTL
===================

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  upstream command present.
REQ-005 SHALL have port cmd_ready  output  1  block accepts command this cycle.
REQ-006 SHALL have port cmd_op  input  3  opcode: 000 add, 001 sub, 011 not-a, all others illegal.
REQ-007 SHALL have ports cmd_a, cmd_b  input  8 each  operands.
REQ-008 SHALL have port res_valid  output  1  result present.
REQ-009 SHALL have port res_ready  input  1  downstream accepts result.
REQ-010 SHALL have port res_data  output  8  result value.
REQ-011 SHALL have ports res_zero, res_carry, res_illegal  output  1 each  result flags.
REQ-012 SHALL have port res_tag  output  2  sequence tag of the command producing res_data.

Function
REQ-013 Command accepted on an edge where cmd_valid && cmd_ready; written with op, a, b and current tag into FIFO.
REQ-014 cmd_ready SHALL equal !fifo_full; no same-cycle bypass when full, even if a pop occurs.
REQ-015 Tag counter (2 bit) SHALL increment per accepted command, wrapping 3->0.
REQ-016 FSM states IDLE, EXEC, OUT; IDLE->EXEC when FIFO non-empty; EXEC->OUT always (one cycle).
REQ-017 In EXEC: head entry drives the execution core with enable high; on the exiting edge result, flags and tag SHALL be registered and the FIFO popped.
REQ-018 In OUT: res_valid=1; outputs held stable until res_valid && res_ready; then ->EXEC if FIFO non-empty else ->IDLE.
REQ-019 res_valid SHALL be 1 only in OUT.
REQ-020 Latency: command accepted at edge k into empty FIFO with FSM IDLE -> res_valid high after edge k+2; sustained throughput one result per 2 cycles.
REQ-021 add: res_data=(a+b)[7:0], res_carry=bit 8 of 9-bit sum.
REQ-022 sub: res_data=(a-b)[7:0], res_carry=1 iff a<b (borrow).
REQ-023 not-a: res_data=~a, res_carry=0.
REQ-024 illegal op: res_data=8'h00, res_carry=0, res_illegal=1; otherwise res_illegal=0.
REQ-025 res_zero SHALL be 1 iff res_data==8'h00.
REQ-026 Push and pop on the same edge SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-027 Commands SHALL complete in acceptance order; no command dropped or duplicated.

Reset
REQ-028 While rst=1: FSM->IDLE, FIFO empty, tag counter=0, res_valid=0, res_data=0, res_zero=0, res_carry=0, res_illegal=0, res_tag=0.
REQ-029 Reset mid-operation SHALL discard all queued and in-flight commands; cmd_ready=1 on the first cycle after rst deasserts.
REQ-030 cmd_valid during rst SHALL NOT be accepted.

Structure
REQ-031 Opcode constants and FSM state encodings SHALL live in shared package alu_pkg.
REQ-032 Arithmetic SHALL be in one combinational sub-module alu_exec_core (op, a, b, en -> data, carry, illegal); FIFO and FSM in the top.

Verification
REQ-033 add FF+01 -> res_data=00, res_zero=1, res_carry=1, tag 0, res_valid after edge k+2.
REQ-034 sub 03-05 -> FE, carry=1, zero=0; not-a 0F -> F0, carry=0; op 010 with a=55 -> 00, zero=1, illegal=1.
REQ-035 res_ready=0, push continuously: 5 commands accepted (1 in OUT + 4 queued), then cmd_ready=0; release res_ready -> all 5 results in order, tags 0..3,0.
REQ-036 res_ready toggled randomly for 50 commands -> outputs stable while res_valid && !res_ready; results match model in order.
REQ-037 rst asserted with 3 queued and one in OUT -> next cycle res_valid=0, cmd_ready=1; next command returns tag 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit:
// opcodes, FSM states and the queued command record.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] tag;
    } cmd_t;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational execution core: add, sub, not-a.
// Outputs are all zero while en is low.
module alu_exec_core
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       en,
    output logic [7:0] data,
    output logic       carry,
    output logic       illegal
);

    logic [8:0] sum;
    logic [8:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Opcode decode; bit 8 of the 9-bit difference is the borrow (a < b)
    always_comb begin
        data    = 8'h00;
        carry   = 1'b0;
        illegal = 1'b0;
        if (en) begin
            case (op)
                OP_ADD: begin
                    data  = sum[7:0];
                    carry = sum[8];
                end
                OP_SUB: begin
                    data  = diff[7:0];
                    carry = diff[8];
                end
                OP_NOT: begin
                    data = ~a;
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue unit: command FIFO, tag counter and
// IDLE/EXEC/OUT sequencer around alu_exec_core.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_zero,
    output logic       res_carry,
    output logic       res_illegal,
    output logic [1:0] res_tag
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    tag;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    cmd_t          head;

    state_t        state;
    state_t        next_state;

    logic [7:0]    core_data;
    logic          core_carry;
    logic          core_illegal;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == ST_EXEC);
    assign head      = mem[rd_ptr];
    assign res_valid = (state == ST_OUT);

    // Command storage; contents need no reset since count gates use
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, tag: tag};
        end
    end

    // FIFO pointers, occupancy and sequence tag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tag    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                tag    <= tag + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sequencer next-state: one EXEC cycle, then hold in OUT until taken
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                next_state = ST_OUT;
            end
            ST_OUT: begin
                if (res_ready) begin
                    next_state = empty ? ST_IDLE : ST_EXEC;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    alu_exec_core u_core (
        .op      (head.op),
        .a       (head.a),
        .b       (head.b),
        .en      (pop),
        .data    (core_data),
        .carry   (core_carry),
        .illegal (core_illegal)
    );

    // Result registers capture the core on the EXEC exit edge
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data    <= 8'h00;
            res_zero    <= 1'b0;
            res_carry   <= 1'b0;
            res_illegal <= 1'b0;
            res_tag     <= 2'd0;
        end else if (pop) begin
            res_data    <= core_data;
            res_zero    <= (core_data == 8'h00);
            res_carry   <= core_carry;
            res_illegal <= core_illegal;
            res_tag     <= head.tag;
        end
    end

endmodule
